// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EX elastic stage: skid state encoding and
// payload layout helpers used when packing and unpacking the payload vector.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } skid_state_t;

   localparam int DEF_DATA_W     = 64;
   localparam int DEF_NUM_SRC    = 2;
   localparam int DEF_REG_ADDR_W = 4;
   localparam int PAYLOAD_W      = 2 + DEF_REG_ADDR_W + DEF_NUM_SRC * DEF_DATA_W;

   // Payload layout, LSB first: wreg_en, wmem_en, wreg_addr, operand words
   localparam int WREG_EN_POS = 0;
   localparam int WMEM_EN_POS = 1;
   localparam int ADDR_LSB    = 2;

   function automatic int payload_width(input int reg_addr_w, input int num_src,
                                        input int data_w);
      return 2 + reg_addr_w + num_src * data_w;
   endfunction

   function automatic int data_lsb(input int reg_addr_w);
      return ADDR_LSB + reg_addr_w;
   endfunction

endpackage

// File: rtl/pipe_skid_core.sv
// Generic two-entry valid/ready skid buffer on an opaque payload, with a
// registered in_ready and a synchronous flush that empties both entries.
module pipe_skid_core
   import pipe_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   skid_state_t  state;
   skid_state_t  state_n;
   logic         ready_q;
   logic         ready_n;
   logic [W-1:0] main_q;
   logic [W-1:0] skid_q;
   logic         load_main_in;
   logic         load_main_skid;
   logic         load_skid;
   logic         in_acc;
   logic         out_acc;

   assign out_valid = (state != EMPTY);
   assign in_ready  = ready_q;
   assign out_data  = main_q;
   assign in_acc    = in_valid & ready_q;
   assign out_acc   = out_valid & out_ready;

   // Flush wins over everything; payload registers keep their contents then
   always_comb begin
      state_n        = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         state_n = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (in_acc) begin
                  load_main_in = 1'b1;
                  state_n      = ONE;
               end
            end
            ONE: begin
               if (in_acc && out_acc) begin
                  load_main_in = 1'b1;
               end else if (in_acc) begin
                  load_skid = 1'b1;
                  state_n   = TWO;
               end else if (out_acc) begin
                  state_n = EMPTY;
               end
            end
            TWO: begin
               if (out_acc) begin
                  load_main_skid = 1'b1;
                  state_n        = ONE;
               end
            end
            default: state_n = EMPTY;
         endcase
      end
      ready_n = (state_n != TWO);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= EMPTY;
         ready_q <= 1'b1;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state   <= state_n;
         ready_q <= ready_n;
         if (load_main_in) begin
            main_q <= in_data;
         end else if (load_main_skid) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= in_data;
         end
      end
   end

endmodule

// File: rtl/id_ex_skid_stage.sv
// Elastic ID->EX pipeline stage: packs decoded control and operands into a
// skid core, squashes r0 writes, gates controls by valid and counts stalls.
module id_ex_skid_stage
   import pipe_pkg::*;
#(
   parameter int DATA_W      = 64,
   parameter int NUM_SRC     = 2,
   parameter int REG_ADDR_W  = 4,
   parameter int ZERO_SQUASH = 1,
   parameter int CNT_W       = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      in_wreg_en,
   input  logic                      in_wmem_en,
   input  logic [NUM_SRC*DATA_W-1:0] in_rdata,
   input  logic [REG_ADDR_W-1:0]     in_wreg_addr,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      out_wreg_en,
   output logic                      out_wmem_en,
   output logic [NUM_SRC*DATA_W-1:0] out_rdata,
   output logic [REG_ADDR_W-1:0]     out_wreg_addr,
   output logic [CNT_W-1:0]          stall_cnt
);

   localparam int PW   = payload_width(REG_ADDR_W, NUM_SRC, DATA_W);
   localparam int DLSB = data_lsb(REG_ADDR_W);
   localparam int RW   = NUM_SRC * DATA_W;

   logic          cap_wreg_en;
   logic [PW-1:0] in_payload;
   logic [PW-1:0] main_payload;

   // Writes to register 0 are dropped at capture so they never leave the stage
   assign cap_wreg_en = (ZERO_SQUASH != 0) ? (in_wreg_en & (|in_wreg_addr)) : in_wreg_en;
   assign in_payload  = {in_rdata, in_wreg_addr, in_wmem_en, cap_wreg_en};

   pipe_skid_core #(
      .W(PW)
   ) u_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_payload),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (main_payload)
   );

   assign out_wreg_en   = out_valid & main_payload[WREG_EN_POS];
   assign out_wmem_en   = out_valid & main_payload[WMEM_EN_POS];
   assign out_wreg_addr = main_payload[ADDR_LSB +: REG_ADDR_W];
   assign out_rdata     = main_payload[DLSB +: RW];

   // Saturating back-pressure counter; only reset clears it, flush does not
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: doc/id_ex_skid_stage.md
Name: id_ex_skid_stage

Overview:
Parametrised, elastic successor to the plain enable-gated ID pipeline register. It carries the decoded control bits (register write enable, memory write enable, destination register) and NUM_SRC operand words from ID to EX. A valid/ready handshake backed by a 2-entry skid buffer replaces the global en_reg. It also adds synchronous flush, bubble squashing of control bits, an optional register-0 write squash and a saturating back-pressure counter.

Parameters:
DATA_W, 64, operand word width
NUM_SRC, 2, number of operand words carried (1..4)
REG_ADDR_W, 4, destination register address width
ZERO_SQUASH, 1, 1 = force write enable to 0 when the captured destination address is 0
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
flush  in  1  synchronous squash of all held entries
in_valid  in  1  upstream has an instruction
in_ready  out  1  stage can accept (registered)
in_wreg_en  in  1  register write enable
in_wmem_en  in  1  memory write enable
in_rdata  in  NUM_SRC*DATA_W  operand words, src0 in LSBs
in_wreg_addr  in  REG_ADDR_W  destination register
out_valid  out  1  main entry valid
out_ready  in  1  downstream accepts
out_wreg_en  out  1  gated by out_valid
out_wmem_en  out  1  gated by out_valid
out_rdata  out  NUM_SRC*DATA_W  main entry operands
out_wreg_addr  out  REG_ADDR_W  main entry destination
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0

Behaviour:
- Reset: state EMPTY. in_ready=1; out_valid=0; out_wreg_en=0; out_wmem_en=0; out_rdata=0; out_wreg_addr=0; stall_cnt=0. The skid payload is also 0.
- Transfer rules: input accept = in_valid & in_ready. Output accept = out_valid & out_ready.
- Latency: 1 cycle from input accept in EMPTY to out_valid=1. Outputs come straight from the main registers, with no combinational path from in_* to out_*.
- States and transitions:
  - EMPTY: on input accept, main <= in and go to ONE.
  - ONE, input accept and output accept: main <= in, stay in ONE.
  - ONE, input accept without output accept: skid <= in, go to TWO, in_ready <= 0.
  - ONE, output accept only: go to EMPTY.
  - TWO: in_ready=0. On output accept, main <= skid, go to ONE, in_ready <= 1.
- in_ready is registered: it is 1 exactly when next state != TWO. It is never combinationally dependent on out_ready.
- Flush has the highest priority and acts at the next edge:
  - state goes to EMPTY, out_valid goes to 0 and in_ready goes to 1;
  - an input offered in the flush cycle is dropped even though in_ready was 1;
  - payload registers hold their values, but control outputs read 0 because of out_valid gating.
- Bubble gating: out_wreg_en = out_valid & main_wreg_en, and likewise for out_wmem_en. An invalid stage therefore never writes.
- ZERO_SQUASH=1: at capture, the stored wreg_en = in_wreg_en & (in_wreg_addr != 0). wmem_en is unaffected.
- stall_cnt: increments each cycle with out_valid & !out_ready. It saturates at 2^CNT_W-1, is unaffected by flush and is cleared only by reset.
- Asynchronous reset asserted mid-transfer discards both entries immediately.
- Ordering: entries leave in acceptance order. The skid entry is never presented before main.

Decomposition:
- Shared package pipe_pkg holds:
  - the state encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2);
  - localparam PAYLOAD_W = 2 + REG_ADDR_W + NUM_SRC*DATA_W;
  - the payload field offsets for packing and unpacking.
- Natural sub-module: pipe_skid_core. It is a generic valid/ready 2-entry skid on an opaque PAYLOAD_W vector with flush.
- The top level adds packing, ZERO_SQUASH, output gating and stall_cnt.

Test Plan:
- Reset, then in_valid=1 with wreg_en=1, addr=3 and operands 0x11/0x22, out_ready=1 -> one cycle later out_valid=1, out_wreg_en=1, out_wreg_addr=3, out_rdata={0x22,0x11}. in_ready stays 1.
- Stream A, B, C back-to-back, hold out_ready=0 after A enters -> B goes to skid and in_ready=0 the next cycle; C is held upstream. Release out_ready -> outputs A, B, C in order with no loss or duplication. stall_cnt equals the stalled cycle count.
- Pulse flush while in TWO, with in_valid=1 carrying D -> next cycle out_valid=0, out_wreg_en=0, out_wmem_en=0, in_ready=1, and D never appears at the output.
- ZERO_SQUASH=1, accept wreg_en=1 with addr=0 -> out_wreg_en=0 while out_valid=1. With addr=5 -> out_wreg_en=1.
- CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt saturates at 15. It is still 15 after a flush and returns to 0 only on rst_n.
- Assert rst_n=0 asynchronously mid-cycle while in TWO -> outputs go to 0 immediately with no wait for clk. After release, in_ready=1.
